audio_mixer_duck: RTL and testbench



---
 rtl/audio_mix_pkg.sv | 40 ++++
 rtl/duck_envelope.sv | 66 ++++++
 rtl/audio_mixer_duck.sv | 184 ++++++++++++++++++
 tb/tb_audio_mixer_duck.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_mix_pkg
//   Shared types and sizing helpers for the ducking audio mixer.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package audio_mix_pkg;

  // Frame-processing sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_SCALE = 3'd2,
    ST_SAT   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Gain code that represents 1.0
  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Accumulator width: full product plus headroom for summing every channel
  function automatic int acc_width(input int w, input int gain_w, input int num_ch);
    return w + gain_w + 1 + $clog2(num_ch);
  endfunction

  // Clamp a wide signed value into a signed w-bit range
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duck_envelope.sv
`default_nettype none
// ---------------------------------------------------------------------------
// duck_envelope
//   Ramped ducking gain: attacks toward a floor while the priority channel is
//   active, holds for a number of samples after it goes quiet, then releases
//   back toward unity.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module duck_envelope
  import audio_mix_pkg::*;
#(
  parameter int GAIN_W       = 8,
  parameter int DUCK_FLOOR   = 32,
  parameter int DUCK_STEP    = 16,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update,
  input  logic              prio_active,
  input  logic              duck_en,
  output logic [GAIN_W-1:0] duck_gain
);

  // Extended width so gain +/- step never wraps
  localparam int EW    = GAIN_W + 2;
  localparam int HW    = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [EW-1:0] UNITY_E = EW'(unity_gain(GAIN_W));
  localparam logic [EW-1:0] FLOOR_E = EW'(DUCK_FLOOR);
  localparam logic [EW-1:0] STEP_E  = EW'(DUCK_STEP);
  localparam logic [HW-1:0] HOLD_C  = HW'(HOLD_SAMPLES);

  logic [HW-1:0] hold_cnt;
  logic [EW-1:0] gain_e;
  logic [EW-1:0] gain_dn;
  logic [EW-1:0] gain_up;

  // Candidate next gains for attack and release, clamped to floor / unity
  always_comb begin
    gain_e  = {2'b00, duck_gain};
    gain_dn = (gain_e >= FLOOR_E + STEP_E) ? (gain_e - STEP_E) : FLOOR_E;
    gain_up = (gain_e + STEP_E <= UNITY_E) ? (gain_e + STEP_E) : UNITY_E;
  end

  // Envelope state advances once per completed frame
  always_ff @(posedge clk) begin
    if (rst) begin
      duck_gain <= UNITY_E[GAIN_W-1:0];
      hold_cnt  <= '0;
    end else if (update) begin
      if (!duck_en) begin
        duck_gain <= UNITY_E[GAIN_W-1:0];
        hold_cnt  <= '0;
      end else if (prio_active) begin
        duck_gain <= gain_dn[GAIN_W-1:0];
        hold_cnt  <= HOLD_C;
      end else if (hold_cnt != '0) begin
        hold_cnt  <= hold_cnt - 1'b1;
      end else begin
        duck_gain <= gain_up[GAIN_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_mixer_duck.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_mixer_duck
//   N-channel mixer with per-channel gain and mute, one priority channel that
//   ducks all others through a ramped envelope, and explicit saturation.
//   One shared multiplier is stepped across the channels each frame.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module audio_mixer_duck
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int W            = 16,
  parameter int GAIN_W       = 8,
  parameter int DUCK_CH      = 0,
  parameter int DUCK_FLOOR   = 32,
  parameter int DUCK_STEP    = 16,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [NUM_CH*W-1:0]      ch_data,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic                     duck_en,
  output logic signed [W-1:0]      mix_out,
  output logic                     mix_valid,
  output logic                     clip,
  output logic                     overrun,
  output logic                     busy
);

  localparam int PW    = W + GAIN_W + 1;
  localparam int AW    = acc_width(W, GAIN_W, NUM_CH);
  localparam int SW    = AW + GAIN_W + 2;
  localparam int IDXW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GAIN_W:0]   UNITY_G = (GAIN_W + 1)'(unity_gain(GAIN_W));
  localparam logic [IDXW-1:0]   LAST_CH = IDXW'(NUM_CH - 1);
  localparam logic [IDXW-1:0]   PRIO_CH = IDXW'(DUCK_CH);

  // Frame snapshot
  logic [NUM_CH*W-1:0]      cap_data;
  logic [NUM_CH*GAIN_W-1:0] cap_gain;
  logic [NUM_CH-1:0]        cap_mute;
  logic                     cap_duck_en;

  state_t                   state;
  logic [IDXW-1:0]          ch_idx;
  logic signed [AW-1:0]     acc_fg;
  logic signed [AW-1:0]     acc_bg;
  logic signed [SW-1:0]     wide_r;
  logic signed [W-1:0]      sat_r;
  logic                     clip_next;
  logic [GAIN_W-1:0]        duck_gain;
  logic                     prio_active;

  logic signed [W-1:0]      cur_sample;
  logic [GAIN_W-1:0]        cur_gain;
  logic                     cur_mute;
  logic signed [PW-1:0]     cur_prod;
  logic signed [AW-1:0]     prod_ext;

  logic signed [AW-1:0]     fg_sh;
  logic signed [AW-1:0]     bg_sh;
  logic [GAIN_W:0]          eff_gain;
  logic signed [SW-1:0]     bg_mul;
  logic signed [SW-1:0]     wide;
  logic signed [63:0]       wide64;
  logic signed [63:0]       sat64;

  // Shared multiplier: product of the channel currently selected by ch_idx
  always_comb begin
    cur_sample = cap_data[ch_idx*W +: W];
    cur_gain   = cap_gain[ch_idx*GAIN_W +: GAIN_W];
    cur_mute   = cap_mute[ch_idx];
    cur_prod   = '0;
    if (!cur_mute) begin
      cur_prod = $signed({{(PW-W){cur_sample[W-1]}}, cur_sample})
               * $signed({{(PW-GAIN_W){1'b0}}, cur_gain});
    end
    prod_ext = {{(AW-PW){cur_prod[PW-1]}}, cur_prod};
  end

  // Scale: drop the gain fraction, apply the duck gain to background only
  always_comb begin
    fg_sh    = acc_fg >>> (GAIN_W - 1);
    bg_sh    = acc_bg >>> (GAIN_W - 1);
    eff_gain = cap_duck_en ? {1'b0, duck_gain} : UNITY_G;
    bg_mul   = $signed({{(SW-AW){bg_sh[AW-1]}}, bg_sh})
             * $signed({{(SW-GAIN_W-1){1'b0}}, eff_gain});
    wide     = $signed({{(SW-AW){fg_sh[AW-1]}}, fg_sh}) + (bg_mul >>> (GAIN_W - 1));
  end

  // Clamp the scaled sum to the output range
  always_comb begin
    wide64 = {{(64-SW){wide_r[SW-1]}}, wide_r};
    sat64  = saturate(wide64, W);
  end

  // Priority channel counts as active only if audible and ducking is enabled
  always_comb begin
    prio_active = (cap_data[DUCK_CH*W +: W] != '0) && !cap_mute[DUCK_CH] && cap_duck_en;
  end

  // Frame sequencer: capture, accumulate per channel, scale, clamp, publish
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ch_idx      <= '0;
      acc_fg      <= '0;
      acc_bg      <= '0;
      cap_data    <= '0;
      cap_gain    <= '0;
      cap_mute    <= '0;
      cap_duck_en <= 1'b0;
      wide_r      <= '0;
      sat_r       <= '0;
      clip_next   <= 1'b0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            cap_data    <= ch_data;
            cap_gain    <= ch_gain;
            cap_mute    <= ch_mute;
            cap_duck_en <= duck_en;
            acc_fg      <= '0;
            acc_bg      <= '0;
            ch_idx      <= '0;
            busy        <= 1'b1;
            state       <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (ch_idx == PRIO_CH) acc_fg <= acc_fg + prod_ext;
          else                   acc_bg <= acc_bg + prod_ext;
          if (ch_idx == LAST_CH) state  <= ST_SCALE;
          else                   ch_idx <= ch_idx + 1'b1;
        end
        ST_SCALE: begin
          wide_r <= wide;
          state  <= ST_SAT;
        end
        ST_SAT: begin
          sat_r     <= sat64[W-1:0];
          clip_next <= (sat64 != wide64);
          state     <= ST_OUT;
        end
        ST_OUT: begin
          mix_out   <= sat_r;
          clip      <= clip_next;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  duck_envelope #(
    .GAIN_W       (GAIN_W),
    .DUCK_FLOOR   (DUCK_FLOOR),
    .DUCK_STEP    (DUCK_STEP),
    .HOLD_SAMPLES (HOLD_SAMPLES)
  ) u_env (
    .clk         (clk),
    .rst         (rst),
    .update      (state == ST_OUT),
    .prio_active (prio_active),
    .duck_en     (cap_duck_en),
    .duck_gain   (duck_gain)
  );

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer_duck.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_audio_mixer_duck
//   Scoreboard bench: each issued frame pushes its expected output, a monitor
//   pops and compares on every mix_valid.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_audio_mixer_duck;

  localparam int NUM_CH = 2;
  localparam int W      = 16;
  localparam int GAIN_W = 8;
  localparam int DCH    = 0;
  localparam int FLOOR  = 32;
  localparam int STEP   = 16;
  localparam int HOLD   = 4;
  localparam int UNITY  = 128;
  localparam int LAT    = NUM_CH + 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sample_tick;
  logic [NUM_CH*W-1:0]      ch_data;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [NUM_CH-1:0]        ch_mute;
  logic                     duck_en;
  logic signed [W-1:0]      mix_out;
  logic                     mix_valid;
  logic                     clip;
  logic                     overrun;
  logic                     busy;

  typedef struct {
    int     val;
    bit     clp;
    longint at;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     exp_ovr = 0;
  int     got_ovr = 0;
  int     m_duck = UNITY;
  int     m_hold = 0;

  audio_mixer_duck #(
    .NUM_CH(NUM_CH), .W(W), .GAIN_W(GAIN_W), .DUCK_CH(DCH),
    .DUCK_FLOOR(FLOOR), .DUCK_STEP(STEP), .HOLD_SAMPLES(HOLD)
  ) u_dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_data(ch_data),
    .ch_gain(ch_gain), .ch_mute(ch_mute), .duck_en(duck_en),
    .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: integer mix with floor shifts, then one envelope step
  task automatic model_push(input int s0, input int s1, input int g0, input int g1,
                            input bit m0, input bit m1, input bit en);
    int     s[NUM_CH];
    int     g[NUM_CH];
    bit     m[NUM_CH];
    longint fg, bg, p, wv;
    int     dg;
    bit     c;
    exp_t   e;
    s = '{s0, s1}; g = '{g0, g1}; m = '{m0, m1};
    fg = 0; bg = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      p = m[i] ? 0 : longint'(s[i]) * g[i];
      if (i == DCH) fg += p; else bg += p;
    end
    dg = en ? m_duck : UNITY;
    wv = (fg >>> 7) + (((bg >>> 7) * dg) >>> 7);
    c  = 1'b0;
    if (wv > 32767)  begin wv = 32767;  c = 1'b1; end
    if (wv < -32768) begin wv = -32768; c = 1'b1; end
    e.val = int'(wv); e.clp = c; e.at = cyc + 1 + LAT;
    sb.push_back(e);
    if (!en) begin
      m_duck = UNITY; m_hold = 0;
    end else if (s[DCH] != 0 && !m[DCH]) begin
      m_duck = (m_duck - STEP < FLOOR) ? FLOOR : m_duck - STEP;
      m_hold = HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      m_duck = (m_duck + STEP > UNITY) ? UNITY : m_duck + STEP;
    end
  endtask

  task automatic apply(input int s0, input int s1, input int g0, input int g1,
                       input bit m0, input bit m1, input bit en);
    ch_data = {W'(s1), W'(s0)};
    ch_gain = {GAIN_W'(g1), GAIN_W'(g0)};
    ch_mute = {m1, m0};
    duck_en = en;
  endtask

  // Issue one frame from a negedge; returns on the negedge where the next may start
  task automatic send_frame(input int s0, input int s1, input int g0, input int g1,
                            input bit m0, input bit m1, input bit en);
    apply(s0, s1, g0, g1, m0, m1, en);
    model_push(s0, s1, g0, g1, m0, m1, en);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    check("busy_after_tick", busy, 1);
    sample_tick = 1'b0;
    // scramble the live inputs: the frame must use its snapshot
    ch_data = NUM_CH*W'($urandom);
    ch_gain = NUM_CH*GAIN_W'($urandom);
    ch_mute = NUM_CH'($urandom);
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic model_reset();
    m_duck = UNITY; m_hold = 0;
    sb.delete();
  endtask

  // Monitor: compare every published sample against the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (overrun) got_ovr++;
    if (mix_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got mix_out %0d with no frame outstanding", mix_out);
      end else begin
        e = sb.pop_front();
        check("mix_out", mix_out, e.val);
        check("clip", clip, e.clp);
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    int s0, s1, g0, g1;
    bit m0, m1, en;
    rst = 1'b1; sample_tick = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip, 0);
    check("rst_duck_gain", u_dut.u_env.duck_gain, UNITY);

    // single background channel at unity
    send_frame(0, 1000, 128, 128, 0, 0, 0);
    // saturation both directions
    send_frame(30000, 30000, 255, 128, 0, 0, 0);
    send_frame(-30000, -30000, 255, 128, 0, 0, 0);
    // gain 0 and muted priority
    send_frame(12345, -500, 0, 200, 0, 0, 0);
    send_frame(12345, -500, 255, 200, 1, 0, 0);

    // ducking attack then release
    for (int i = 0; i < 8; i++) send_frame(100, 1000, 128, 128, 0, 0, 1);
    for (int i = 0; i < 12; i++) send_frame(0, 1000, 128, 128, 0, 0, 1);

    // overrun: tick while accumulating, and tick in the publishing cycle
    apply(300, -700, 128, 64, 0, 0, 0);
    model_push(300, -700, 128, 64, 0, 0, 0);
    sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    @(negedge clk) sample_tick = 1'b1;
    exp_ovr++;
    @(posedge clk); #1;
    check("overrun_in_acc", overrun, 1);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    exp_ovr++;
    @(posedge clk); #1;
    check("overrun_in_out", overrun, 1);
    check("valid_with_out_tick", mix_valid, 1);
    sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_out_tick", busy, 0);

    // reset in the middle of accumulation aborts the frame
    apply(5000, 6000, 128, 128, 0, 0, 1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_mix_out", mix_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_duck_gain", u_dut.u_env.duck_gain, UNITY);
    repeat (10) @(negedge clk);

    // randomized frames, priority channel often silent to exercise release
    for (int i = 0; i < 40; i++) begin
      s0 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
      s1 = int'($urandom_range(0, 65535)) - 32768;
      g0 = int'($urandom_range(0, 255));
      g1 = int'($urandom_range(0, 255));
      m0 = ($urandom_range(0, 7) == 0);
      m1 = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 5) != 0);
      send_frame(s0, s1, g0, g1, m0, m1, en);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("overrun_count", got_ovr, exp_ovr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
